upconvert_hold: RTL
===================

# upconvert_hold

Transmit-side counterpart of the receive-path decimator. It takes one input sample per FACTOR output-rate ticks and produces FACTOR output samples, by sample-and-hold or by zero-stuffing. It sits between the TX sample source (which it pulls with `sample_req`) and the interpolating filter chain clocked by the output-rate strobe. It keeps a one-deep pending buffer so the source has a full input period to answer a request.

## Interface
- `WIDTH`, 16: sample width in bits.
- `FACTOR`, 8: upsampling ratio; legal range 2..256.
- `CNT_W`, 8: phase counter width; must satisfy 2^CNT_W >= FACTOR.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `strobe_out`  in  1  output-rate tick, one-cycle pulse, at most one per clk.
- `strobe_in`  in  1  input sample valid, one-cycle pulse.
- `datain`  in  WIDTH  input sample, two's complement; sampled when `strobe_in`=1.
- `zero_stuff`  in  1  0 = hold the current sample for all phases; 1 = output zero on phases 1..FACTOR-1. Quasi-static.
- `dataout`  out  WIDTH  output sample, registered.
- `pul`  out  1  output valid, one-cycle pulse per `strobe_out`.
- `sample_req`  out  1  one-cycle request for the next input sample.
- `underrun`  out  1  sticky; set when phase 0 occurs with no pending sample.
- `overflow`  out  1  sticky; set when a pending sample is overwritten.

## Operation
- State:
  - `phase` counter, 0..FACTOR-1; advances only on `strobe_out` and wraps from FACTOR-1 to 0.
  - `cur` register: the current held sample.
  - `nxt` register and `nxt_valid` flag: the pending sample.
- Input write, on `strobe_in`:
  - `nxt`<=`datain` and `nxt_valid`<=1.
  - If `nxt_valid` was already 1 and is not being consumed in the same cycle, the old value is lost and `overflow`<=1.
- Output on `strobe_out` with `phase`==0 (consume):
  - If `nxt_valid`=1: `cur`<=`nxt`, `dataout`<=`nxt`, and `nxt_valid` is cleared.
  - Else: `cur`<=0, `dataout`<=0, and `underrun`<=1.
- Output on `strobe_out` with `phase`!=0:
  - `zero_stuff`=0: `dataout`<=`cur`.
  - `zero_stuff`=1: `dataout`<=0.
- `pul`<=1 on every cycle that registers a `strobe_out`; otherwise 0.
- `dataout` holds its value between pulses.
- `sample_req` pulses in two cases:
  - on every consume that empties `nxt_valid`;
  - once on the first cycle after `reset` deasserts.
- Simultaneous consume and `strobe_in` in the same cycle:
  - The consume takes the old `nxt`.
  - The new `datain` lands in `nxt` with `nxt_valid`=1.
  - No overflow, no underrun.
  - No `sample_req` is issued, because the slot was refilled.
- No arithmetic is performed; samples pass bit-exact.
- Reset mid-operation: pending and held data are discarded and all state returns to reset values.

## Timing
- Reset values: `dataout`=0, `pul`=0, `sample_req`=0, `underrun`=0, `overflow`=0, `phase`=0, `cur`=0, `nxt_valid`=0.
- Output latency: `strobe_out` at cycle t gives `pul`=1 and a valid `dataout` at t+1.
- Request latency: consume at cycle t gives `sample_req`=1 at t+1.
- Post-reset request: `reset` low first sampled at cycle r gives `sample_req`=1 at r+1.
- Input is usable at the next phase 0 if `strobe_in` arrives at or before the cycle of that `strobe_out`.
- Back-to-back `strobe_out` on consecutive clocks is legal; each produces its own `pul`.
- `strobe_in` and `strobe_out` are independent; any alignment is legal.
- `underrun` and `overflow` clear only on `reset`.

## Test plan
- **Hold mode:** FACTOR=8, `zero_stuff`=0. After reset, answer `sample_req` with 0x1234, then 16 `strobe_out` ticks spaced 3 clocks, with 0xABCD supplied after the first consume. Expect 8 `pul` with 0x1234, then 8 `pul` with 0xABCD; `underrun`=0.
- **Zero-stuff mode:** same stimulus with `zero_stuff`=1. Expect the sequence 0x1234, 0 ×7, 0xABCD, 0 ×7.
- **Underrun:** no `strobe_in` before the first `strobe_out`. Expect `dataout`=0 at t+1 and `underrun`=1. A later 0x0055 plus 8 more ticks yields 0x0055 held for 8 pulses; `underrun` stays 1.
- **Overflow:** two `strobe_in` pulses (0x1111, then 0x2222) before a phase-0 tick. Expect `overflow`=1 and the consumed value 0x2222.
- **Simultaneous events:** `strobe_in`=0x7FFF in the same cycle as a phase-0 `strobe_out` with 0x8000 pending. Expect output 0x8000, `nxt`=0x7FFF valid, no `sample_req`, no flags. The next phase 0 outputs 0x7FFF.
- **Reset mid-operation:** assert `reset` at phase 5 with a sample pending. Expect all outputs 0 next cycle and `sample_req` 1 cycle after release. The next `strobe_out` underruns at phase 0.

Source files
------------

// File: rtl/upconvert_hold.sv
// Integer-factor upconverter: one input sample per FACTOR output ticks, emitted either
// as sample-and-hold or zero-stuffed, with a one-deep pending buffer pulled via sample_req.
module upconvert_hold #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FACTOR = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_out,
    input  logic             strobe_in,
    input  logic [WIDTH-1:0] datain,
    input  logic             zero_stuff,
    output logic [WIDTH-1:0] dataout,
    output logic             pul,
    output logic             sample_req,
    output logic             underrun,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LastPhase = CNT_W'(FACTOR - 1);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] nxt_q, nxt_d;
    logic             nxt_valid_q, nxt_valid_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             pul_q, pul_d;
    logic             sample_req_q, sample_req_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             first_q;
    logic             consume;
    logic             bypass;

    assign consume = strobe_out && (phase_q == '0);
    // Empty slot with a coincident input: the new sample is consumed directly.
    assign bypass  = consume && !nxt_valid_q && strobe_in;

    always_comb begin
        phase_d      = phase_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        nxt_valid_d  = nxt_valid_q;
        dataout_d    = dataout_q;
        pul_d        = strobe_out;
        sample_req_d = first_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;

        if (strobe_out) begin
            phase_d = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
        end

        if (consume) begin
            if (nxt_valid_q) begin
                cur_d       = nxt_q;
                dataout_d   = nxt_q;
                nxt_valid_d = 1'b0;
            end else if (strobe_in) begin
                cur_d     = datain;
                dataout_d = datain;
            end else begin
                cur_d      = '0;
                dataout_d  = '0;
                underrun_d = 1'b1;
            end
        end else if (strobe_out) begin
            dataout_d = zero_stuff ? '0 : cur_q;
        end

        if (strobe_in) begin
            nxt_d = datain;
            if (!bypass) begin
                nxt_valid_d = 1'b1;
            end
            if (nxt_valid_q && !consume) begin
                overflow_d = 1'b1;
            end
        end

        // Request only when a sample was actually taken and the slot is left empty.
        if (consume && (nxt_valid_q || strobe_in) && !nxt_valid_d) begin
            sample_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            cur_q        <= '0;
            nxt_q        <= '0;
            nxt_valid_q  <= 1'b0;
            dataout_q    <= '0;
            pul_q        <= 1'b0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            first_q      <= 1'b1;
        end else begin
            phase_q      <= phase_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            nxt_valid_q  <= nxt_valid_d;
            dataout_q    <= dataout_d;
            pul_q        <= pul_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
            first_q      <= 1'b0;
        end
    end

    assign dataout    = dataout_q;
    assign pul        = pul_q;
    assign sample_req = sample_req_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule
